// File: rtl/uart_rx_frame.sv
// UART receiver: oversampled, 3-sample mid-bit majority vote, 5..9 data bits,
// optional odd/even parity, 1 or 2 stop bits, with parity/framing/break reporting.
module uart_rx_frame #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BIT_RATE   = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  output logic                 VALID,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 BREAK,
  output logic                 BUSY
);

  localparam int DIV = CLK_HZ / (BIT_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int H   = OVERSAMPLE / 2;

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_rx_frame: CLK_HZ/(BIT_RATE*OVERSAMPLE) must be >= 1");
    end
    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_os
      $error("uart_rx_frame: OVERSAMPLE must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("uart_rx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_rx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_rx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA_ST, PAR_ST, STOP_ST, WAIT_IDLE} state_t;

  state_t               state;
  logic                 rx_meta, rxs;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        s;
  logic [3:0]           bit_idx;
  logic                 smp_a, smp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, stop_err, stop_one, fin;
  logic                 tick, decide, bit_end, bitval;

  assign tick    = (div_cnt == DW'(DIV - 1));
  assign decide  = tick && (s == SW'(H + 1));
  assign bit_end = tick && (s == SW'(OVERSAMPLE - 1));
  assign bitval  = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);
  assign BUSY    = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      div_cnt    <= '0;
      s          <= '0;
      bit_idx    <= '0;
      smp_a      <= 1'b1;
      smp_b      <= 1'b1;
      par_bit    <= 1'b0;
      stop_err   <= 1'b0;
      stop_one   <= 1'b0;
      fin        <= 1'b0;
      VALID      <= 1'b0;
      DATA       <= '0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
      BREAK      <= 1'b0;
    end else begin
      VALID <= 1'b0;
      // Timing restarts from zero at every start edge, so it is held clear between frames.
      if (state == IDLE || state == WAIT_IDLE) begin
        div_cnt <= '0;
        s       <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        s       <= (s == SW'(OVERSAMPLE - 1)) ? '0 : s + SW'(1);
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (tick && s == SW'(H - 1)) smp_a <= rxs;
      if (tick && s == SW'(H))     smp_b <= rxs;

      case (state)
        IDLE: begin
          bit_idx  <= '0;
          fin      <= 1'b0;
          stop_err <= 1'b0;
          stop_one <= 1'b0;
          if (!rxs) state <= START;
        end
        START: begin
          if (decide && bitval) state <= IDLE;
          else if (bit_end)     state <= DATA_ST;
        end
        DATA_ST: begin
          if (decide) shreg <= {bitval, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? PAR_ST : STOP_ST;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        PAR_ST: begin
          if (decide)  par_bit <= bitval;
          if (bit_end) state   <= STOP_ST;
        end
        STOP_ST: begin
          // The frame completes at the last stop-bit decision; fin marks the VALID cycle.
          if (fin) begin
            fin   <= 1'b0;
            state <= FRAME_ERR ? WAIT_IDLE : IDLE;
          end else begin
            if (decide) begin
              stop_err <= stop_err | ~bitval;
              stop_one <= stop_one | bitval;
              if (bit_idx == 4'(STOP_BITS - 1)) begin
                fin        <= 1'b1;
                VALID      <= 1'b1;
                DATA       <= shreg;
                PARITY_ERR <= (PARITY != 0) && ((^shreg ^ par_bit) != (PARITY == 1));
                FRAME_ERR  <= stop_err | ~bitval;
                BREAK      <= (shreg == '0) && !((PARITY != 0) && par_bit) && !(stop_one | bitval);
              end
            end
            if (bit_end && bit_idx != 4'(STOP_BITS - 1)) bit_idx <= bit_idx + 4'd1;
          end
        end
        WAIT_IDLE: if (rxs) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three configurations (8N1, 7E1, 8N2) at 115200 baud,
// 8x oversampling, 12 MHz clock; expectations come from a frame-level reference model.
module tb_uart_rx_frame;
  localparam int B = 104;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx   [3];
  logic       v    [3];
  logic       pe   [3];
  logic       fe   [3];
  logic       brk  [3];
  logic       bsy  [3];
  logic [7:0] d0, d2;
  logic [6:0] d1;

  int         n_cmp = 0;
  int         n_bad = 0;

  int         vcnt     [3] = '{0, 0, 0};
  logic [8:0] md       [3];
  logic       mpe      [3];
  logic       mfe      [3];
  logic       mbrk     [3];
  logic       mbusy_v  [3];
  logic       mbusy_nx [3];
  logic       pend     [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  uart_rx_frame #(.CLK_HZ(12_000_000), .BIT_RATE(115200), .OVERSAMPLE(8),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .CLK(clk), .RST(rst), .RX(rx[0]), .VALID(v[0]), .DATA(d0),
    .PARITY_ERR(pe[0]), .FRAME_ERR(fe[0]), .BREAK(brk[0]), .BUSY(bsy[0]));

  uart_rx_frame #(.CLK_HZ(12_000_000), .BIT_RATE(115200), .OVERSAMPLE(8),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .CLK(clk), .RST(rst), .RX(rx[1]), .VALID(v[1]), .DATA(d1),
    .PARITY_ERR(pe[1]), .FRAME_ERR(fe[1]), .BREAK(brk[1]), .BUSY(bsy[1]));

  uart_rx_frame #(.CLK_HZ(12_000_000), .BIT_RATE(115200), .OVERSAMPLE(8),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .CLK(clk), .RST(rst), .RX(rx[2]), .VALID(v[2]), .DATA(d2),
    .PARITY_ERR(pe[2]), .FRAME_ERR(fe[2]), .BREAK(brk[2]), .BUSY(bsy[2]));

  function automatic logic [8:0] dout(int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {2'b0, d1};
      default: return {1'b0, d2};
    endcase
  endfunction

  // Frame-level monitor: counts VALID pulses and records BUSY in and after the VALID cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (v[i]) begin
        vcnt[i]    <= vcnt[i] + 1;
        md[i]      <= dout(i);
        mpe[i]     <= pe[i];
        mfe[i]     <= fe[i];
        mbrk[i]    <= brk[i];
        mbusy_v[i] <= bsy[i];
        pend[i]    <= 1'b1;
      end else if (pend[i]) begin
        mbusy_nx[i] <= bsy[i];
        pend[i]     <= 1'b0;
      end
    end
  end

  // Reference model: rules of the line format, not the receiver's internals.
  function automatic bit good_par(int data, int pm);
    int ones = $countones(data);
    return (pm == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  function automatic bit exp_pe(int data, int pm, bit pb);
    if (pm == 0) return 1'b0;
    return pb != good_par(data, pm);
  endfunction

  function automatic bit exp_fe(int ns, bit [1:0] stops);
    return (ns == 1) ? !stops[0] : !(stops[0] && stops[1]);
  endfunction

  function automatic bit exp_brk(int data, int pm, bit pb, int ns, bit [1:0] stops);
    return data == 0 && (pm == 0 || !pb) && ((ns == 1) ? !stops[0] : (stops == 2'b00));
  endfunction

  task automatic line(int i, bit val, int clocks);
    rx[i] = val;
    repeat (clocks) @(negedge clk);
  endtask

  task automatic send_frame(int i, int data, int nb, int pm, bit pb, int ns, bit [1:0] stops);
    line(i, 1'b0, B);
    for (int b = 0; b < nb; b++) line(i, data[b], B);
    if (pm != 0) line(i, pb, B);
    for (int k = 0; k < ns; k++) line(i, stops[k], B);
    rx[i] = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({v[i], pe[i], fe[i], brk[i], bsy[i]} !== 5'b0) begin
        n_bad++; $display("FAIL reset_flags dut%0d: got %b want 00000", i, {v[i], pe[i], fe[i], brk[i], bsy[i]});
      end
      n_cmp++;
      if (dout(i) !== 9'd0) begin
        n_bad++; $display("FAIL reset_data dut%0d: got %0h want 0", i, dout(i));
      end
    end
  endtask

  task automatic test_basic;
    int c0 = vcnt[0];
    send_frame(0, 'hA5, 8, 0, 1'b0, 1, 2'b11);
    line(0, 1'b1, 2 * B);
    n_cmp++; if (vcnt[0] - c0 !== 1)    begin n_bad++; $display("FAIL basic_count: got %0d want 1", vcnt[0] - c0); end
    n_cmp++; if (md[0] !== 9'hA5)       begin n_bad++; $display("FAIL basic_data: got %0h want a5", md[0]); end
    n_cmp++; if ({mpe[0], mfe[0], mbrk[0]} !== 3'b000) begin n_bad++; $display("FAIL basic_flags: got %b want 000", {mpe[0], mfe[0], mbrk[0]}); end
    n_cmp++; if (mbusy_v[0] !== 1'b1)   begin n_bad++; $display("FAIL basic_busy_at_valid: got %b want 1", mbusy_v[0]); end
    n_cmp++; if (mbusy_nx[0] !== 1'b0)  begin n_bad++; $display("FAIL basic_busy_after: got %b want 0", mbusy_nx[0]); end
  endtask

  task automatic test_parity;
    bit pbs [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      int c0 = vcnt[1];
      send_frame(1, 'h03, 7, 2, pbs[k], 1, 2'b11);
      line(1, 1'b1, 2 * B);
      n_cmp++; if (vcnt[1] - c0 !== 1) begin n_bad++; $display("FAIL parity_count: got %0d want 1", vcnt[1] - c0); end
      n_cmp++; if (md[1] !== 9'h03)    begin n_bad++; $display("FAIL parity_data: got %0h want 3", md[1]); end
      n_cmp++;
      if (mpe[1] !== exp_pe('h03, 2, pbs[k])) begin
        n_bad++; $display("FAIL parity_err pb=%0d: got %b want %b", pbs[k], mpe[1], exp_pe('h03, 2, pbs[k]));
      end
    end
  endtask

  task automatic test_false_start;
    int c0 = vcnt[0];
    line(0, 1'b0, 20);
    n_cmp++; if (bsy[0] !== 1'b1) begin n_bad++; $display("FAIL false_start_busy_hi: got %b want 1", bsy[0]); end
    line(0, 1'b1, 50);
    n_cmp++; if (bsy[0] !== 1'b1) begin n_bad++; $display("FAIL false_start_busy_mid: got %b want 1", bsy[0]); end
    line(0, 1'b1, 40);
    n_cmp++; if (bsy[0] !== 1'b0) begin n_bad++; $display("FAIL false_start_busy_lo: got %b want 0", bsy[0]); end
    n_cmp++; if (vcnt[0] !== c0)  begin n_bad++; $display("FAIL false_start_valid: got %0d want 0", vcnt[0] - c0); end
    send_frame(0, 'h5A, 8, 0, 1'b0, 1, 2'b11);
    line(0, 1'b1, 2 * B);
    n_cmp++; if (vcnt[0] - c0 !== 1 || md[0] !== 9'h5A) begin
      n_bad++; $display("FAIL false_start_next: got count %0d data %0h want 1 5a", vcnt[0] - c0, md[0]);
    end
  endtask

  task automatic test_frame_err;
    int c0 = vcnt[0];
    send_frame(0, 'h55, 8, 0, 1'b0, 1, 2'b00);
    line(0, 1'b0, 3 * B);
    n_cmp++; if (vcnt[0] - c0 !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", vcnt[0] - c0); end
    n_cmp++; if ({md[0], mfe[0], mbrk[0]} !== {9'h55, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL ferr_flags: got data %0h fe %b brk %b want 55 1 0", md[0], mfe[0], mbrk[0]);
    end
    line(0, 1'b1, 2 * B);
    n_cmp++; if (vcnt[0] - c0 !== 1) begin n_bad++; $display("FAIL ferr_no_repeat: got %0d want 1", vcnt[0] - c0); end
    send_frame(0, 'h3C, 8, 0, 1'b0, 1, 2'b11);
    line(0, 1'b1, 2 * B);
    n_cmp++; if ({vcnt[0] - c0, md[0], mfe[0]} !== {32'd2, 9'h3C, 1'b0}) begin
      n_bad++; $display("FAIL ferr_recover: got count %0d data %0h fe %b want 2 3c 0", vcnt[0] - c0, md[0], mfe[0]);
    end
  endtask

  task automatic test_break;
    int c0 = vcnt[0];
    line(0, 1'b0, 20 * B);
    line(0, 1'b1, 2 * B);
    n_cmp++; if (vcnt[0] - c0 !== 1) begin n_bad++; $display("FAIL break_count: got %0d want 1", vcnt[0] - c0); end
    n_cmp++; if ({md[0], mbrk[0], mfe[0]} !== {9'h0, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL break_flags: got data %0h brk %b fe %b want 0 1 1", md[0], mbrk[0], mfe[0]);
    end
    send_frame(0, 'hFF, 8, 0, 1'b0, 1, 2'b11);
    line(0, 1'b1, 2 * B);
    n_cmp++; if ({vcnt[0] - c0, md[0], mbrk[0], mfe[0]} !== {32'd2, 9'hFF, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL break_recover: got count %0d data %0h brk %b fe %b want 2 ff 0 0", vcnt[0] - c0, md[0], mbrk[0], mfe[0]);
    end
  endtask

  task automatic test_two_stop;
    bit [1:0] st [2] = '{2'b01, 2'b11};
    for (int k = 0; k < 2; k++) begin
      int c0 = vcnt[2];
      send_frame(2, 'h96, 8, 0, 1'b0, 2, st[k]);
      line(2, 1'b1, 2 * B);
      n_cmp++;
      if ({vcnt[2] - c0, md[2], mfe[2], mbrk[2]} !== {32'd1, 9'h96, exp_fe(2, st[k]), 1'b0}) begin
        n_bad++; $display("FAIL two_stop stops=%b: got count %0d data %0h fe %b brk %b want 1 96 %b 0",
                          st[k], vcnt[2] - c0, md[2], mfe[2], mbrk[2], exp_fe(2, st[k]));
      end
    end
  endtask

  task automatic test_reset_midframe;
    int c0 = vcnt[0];
    line(0, 1'b0, B);
    for (int b = 0; b < 4; b++) line(0, 1'b0, B);
    line(0, 1'b1, 40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({v[0], pe[0], fe[0], brk[0], bsy[0]} !== 5'b0 || dout(0) !== 9'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got flags %b data %0h want 00000 0", {v[0], pe[0], fe[0], brk[0], bsy[0]}, dout(0));
    end
    line(0, 1'b1, 6 * B);
    n_cmp++; if (vcnt[0] !== c0) begin n_bad++; $display("FAIL midreset_valid: got %0d want 0", vcnt[0] - c0); end
    send_frame(0, 'h81, 8, 0, 1'b0, 1, 2'b11);
    line(0, 1'b1, 2 * B);
    n_cmp++; if ({vcnt[0] - c0, md[0], mfe[0]} !== {32'd1, 9'h81, 1'b0}) begin
      n_bad++; $display("FAIL midreset_next: got count %0d data %0h fe %b want 1 81 0", vcnt[0] - c0, md[0], mfe[0]);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 6; n++) begin
        int       nb = (i == 1) ? 7 : 8;
        int       pm = (i == 1) ? 2 : 0;
        int       ns = (i == 2) ? 2 : 1;
        int       data = (n == 0) ? 0 : int'($urandom_range(0, (1 << nb) - 1));
        bit       pb;
        bit [1:0] stops = 2'b11;
        int       c0 = vcnt[i];
        pb = good_par(data, pm) ^ ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 3) == 0) stops[$urandom_range(0, ns - 1)] = 1'b0;
        send_frame(i, data, nb, pm, pb, ns, stops);
        line(i, 1'b1, 2 * B);
        n_cmp++;
        if (vcnt[i] - c0 !== 1 || md[i] !== 9'(data)) begin
          n_bad++; $display("FAIL rand_data dut%0d: got count %0d data %0h want 1 %0h", i, vcnt[i] - c0, md[i], data);
        end
        n_cmp++;
        if ({mpe[i], mfe[i], mbrk[i]} !== {exp_pe(data, pm, pb), exp_fe(ns, stops), exp_brk(data, pm, pb, ns, stops)}) begin
          n_bad++; $display("FAIL rand_flags dut%0d data %0h pb %b stops %b: got %b want %b", i, data, pb, stops,
                            {mpe[i], mfe[i], mbrk[i]},
                            {exp_pe(data, pm, pb), exp_fe(ns, stops), exp_brk(data, pm, pb, ns, stops)});
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) rx[i] = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_parity;
    test_false_start;
    test_frame_err;
    test_break;
    test_two_stop;
    test_reset_midframe;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
